c2h_dsc_byp_sched: RTL and testbench
====================================

Name: c2h_dsc_byp_sched

Overview:
Descriptor-bypass scheduler for the XDMA C2H channel. It replaces the always-load, fixed-address logic with a credit-managed ring of host buffers. For each outgoing C2H packet it issues one bypass descriptor whose destination is the next free slot in a host ring (base from driver config). Slots are recycled only when the host driver returns credits. It sits in the top-level between the packet source (length announce) and the xdma dsc_bypass_c2h_* port, on user_clk_250.

Parameters:
NUM_SLOTS, 16, ring depth; power of two, 2..256
SLOT_SHIFT, 12, log2 slot size in bytes (4 KiB slots)
DSC_CTL, 16'h0000, value driven on dsc_byp_ctl
SLOT_W, $clog2(NUM_SLOTS), slot index width (derived, do not override)

Ports:
user_clk  in  1  clock (user_clk_250 domain)
user_resetn  in  1  asynchronous active-low reset
enable  in  1  driver ready / link up; rising edge (re)initialises the ring
cfg_base_addr  in  64  host ring base; must be slot-aligned
pkt_valid  in  1  upstream announces a packet
pkt_len  in  28  packet length in bytes
pkt_ready  out  1  one-cycle pulse: announcement consumed (issued or dropped)
credit_ret_valid  in  1  host returned slots
credit_ret_cnt  in  SLOT_W+1  number of slots returned
dsc_byp_dst_addr  out  64  descriptor destination
dsc_byp_src_addr  out  64  constant 0
dsc_byp_len  out  28  descriptor length
dsc_byp_ctl  out  16  DSC_CTL
dsc_byp_load  out  1  descriptor valid
dsc_byp_ready  in  1  xdma accepts when load&&ready
credits  out  SLOT_W+1  free slots
slot_idx  out  SLOT_W  next slot to use
desc_count  out  32  descriptors accepted, wraps at 2^32
err_len  out  1  one-cycle pulse on illegal length
err_credit_ovf  out  1  sticky, set when returned credits would exceed NUM_SLOTS

Behaviour:
- Reset values: all outputs 0, except:
  - credits = NUM_SLOTS
  - dsc_byp_ctl = DSC_CTL
  - latched base = 0
- enable rising edge (registered compare): latch cfg_base_addr, slot_idx <= 0, credits <= NUM_SLOTS, err_credit_ovf <= 0. cfg_base_addr changes while enable is high are ignored.
- FSM states: IDLE, LOAD.
- IDLE, all of enable && pkt_valid && credits != 0 && length legal:
  - register dst = base + (slot_idx << SLOT_SHIFT) and len = pkt_len;
  - assert dsc_byp_load the next cycle;
  - go to LOAD.
- IDLE, pkt_valid && enable with pkt_len == 0 or pkt_len > 2^SLOT_SHIFT:
  - pkt_ready pulse and err_len pulse in the same cycle;
  - no descriptor; stay in IDLE.
- IDLE with credits == 0: hold; pkt_ready stays low.
- LOAD:
  - hold load, dst and len stable until dsc_byp_load && dsc_byp_ready.
  - On that cycle: load <= 0, pkt_ready pulse, slot_idx <= slot_idx+1 (wraps NUM_SLOTS-1 -> 0), desc_count++, return to IDLE.
- Latency: pkt_valid sampled in IDLE at cycle t -> load high at t+1. Minimum issue interval is 2 cycles per descriptor.
- enable falling while in LOAD: the descriptor is never withdrawn; LOAD completes normally. No new issue until enable is high.
- Credits:
  - next = credits - accept + (credit_ret_valid ? credit_ret_cnt : 0).
  - Accept and return in the same cycle are both applied.
  - If the sum exceeds NUM_SLOTS: saturate at NUM_SLOTS and set err_credit_ovf.
  - credit_ret_cnt == 0 is a no-op.
- Address arithmetic is 64-bit with no carry checks; the ring must not cross 2^64.
- Asynchronous reset mid-LOAD: load drops immediately and all state returns to reset values.

Test Plan:
1. Reset, base=64'h1_0000_0000, enable=1, three packets of len 28'h1000 with ready tied high -> dst 0x100000000, 0x100001000, 0x100002000; load at t+1; pkt_ready pulses; desc_count=3; credits=13.
2. Issue 16 packets without returns -> 17th packet stalls with pkt_ready low. Pulse credit_ret_cnt=2 -> 17th issues to slot 0 (dst = base, wrap); credits=1.
3. pkt_len=0, then pkt_len=28'h1001 -> err_len and pkt_ready pulse each time; no load; slot_idx and credits unchanged.
4. Hold dsc_byp_ready low 5 cycles in LOAD, dropping enable at cycle 2 -> load, dst and len stable; accepted on cycle 6; no further issue.
5. With credits=16, credit_ret_cnt=1 -> credits stays 16 and err_credit_ovf=1. Accept and a return of 1 in the same cycle -> credits unchanged.
6. Assert user_resetn=0 asynchronously while load=1 -> load=0 before the next edge; credits=16, desc_count=0.

Source files
------------

// File: rtl/c2h_dsc_byp_sched.sv
// C2H descriptor-bypass scheduler: issues one bypass descriptor per announced
// packet into a credit-managed ring of host buffers starting at cfg_base_addr.
module c2h_dsc_byp_sched #(
  parameter int          NUM_SLOTS  = 16,
  parameter int          SLOT_SHIFT = 12,
  parameter logic [15:0] DSC_CTL    = 16'h0000,
  parameter int          SLOT_W     = $clog2(NUM_SLOTS)
) (
  input  logic              user_clk,
  input  logic              user_resetn,
  input  logic              enable,
  input  logic [63:0]       cfg_base_addr,
  input  logic              pkt_valid,
  input  logic [27:0]       pkt_len,
  output logic              pkt_ready,
  input  logic              credit_ret_valid,
  input  logic [SLOT_W:0]   credit_ret_cnt,
  output logic [63:0]       dsc_byp_dst_addr,
  output logic [63:0]       dsc_byp_src_addr,
  output logic [27:0]       dsc_byp_len,
  output logic [15:0]       dsc_byp_ctl,
  output logic              dsc_byp_load,
  input  logic              dsc_byp_ready,
  output logic [SLOT_W:0]   credits,
  output logic [SLOT_W-1:0] slot_idx,
  output logic [31:0]       desc_count,
  output logic              err_len,
  output logic              err_credit_ovf
);

  localparam int              SUM_W      = SLOT_W + 3;
  localparam logic [SLOT_W:0] FULL       = (SLOT_W+1)'(NUM_SLOTS);
  localparam logic [28:0]     SLOT_BYTES = 29'(64'(1) << SLOT_SHIFT);

  // Returns {overflow, clamped credit count}.
  function automatic logic [SLOT_W+1:0] sat_credits(input logic [SUM_W-1:0] sum);
    if (sum > SUM_W'(NUM_SLOTS))
      return {1'b1, FULL};
    return {1'b0, sum[SLOT_W:0]};
  endfunction

  typedef enum logic {IDLE, LOAD} state_t;

  state_t           state, state_nxt;
  logic             enable_p1;
  logic             en_rise;
  logic             len_ok;
  logic             issue;
  logic             drop;
  logic             accept;
  logic [63:0]      base_addr;
  logic [SLOT_W:0]  credit_ret;
  logic [SUM_W-1:0] credit_sum;
  logic [SLOT_W:0]  credits_nxt;
  logic             credit_ovf;

  // Issue is blocked on the enable rising-edge cycle so the ring is
  // re-initialised before the first descriptor address is formed.
  assign en_rise    = enable & ~enable_p1;
  assign len_ok     = (pkt_len != '0) && ({1'b0, pkt_len} <= SLOT_BYTES);
  assign credit_ret = credit_ret_valid ? credit_ret_cnt : '0;
  assign credit_sum = SUM_W'(credits) + SUM_W'(credit_ret) - SUM_W'(accept);
  assign {credit_ovf, credits_nxt} = sat_credits(credit_sum);

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    drop      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && enable_p1 && pkt_valid) begin
          if (!len_ok) begin
            drop = 1'b1;
          end else if (credits != '0) begin
            issue     = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (dsc_byp_load && dsc_byp_ready) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pkt_ready        = drop | accept;
  assign err_len          = drop;
  assign dsc_byp_src_addr = '0;
  assign dsc_byp_ctl      = DSC_CTL;

  // Stage p1: descriptor register, ring pointer and credit bookkeeping.
  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      enable_p1        <= 1'b0;
      base_addr        <= '0;
      dsc_byp_dst_addr <= '0;
      dsc_byp_len      <= '0;
      dsc_byp_load     <= 1'b0;
      slot_idx         <= '0;
      credits          <= FULL;
      desc_count       <= '0;
      err_credit_ovf   <= 1'b0;
    end else begin
      enable_p1 <= enable;
      if (en_rise)
        base_addr <= cfg_base_addr;
      if (issue) begin
        dsc_byp_dst_addr <= base_addr + (64'(slot_idx) << SLOT_SHIFT);
        dsc_byp_len      <= pkt_len;
        dsc_byp_load     <= 1'b1;
      end
      if (accept) begin
        dsc_byp_load <= 1'b0;
        desc_count   <= desc_count + 32'd1;
      end
      if (en_rise) begin
        slot_idx       <= '0;
        credits        <= FULL;
        err_credit_ovf <= 1'b0;
      end else begin
        if (accept)
          slot_idx <= slot_idx + 1'b1;
        credits <= credits_nxt;
        if (credit_ovf)
          err_credit_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_c2h_dsc_byp_sched.sv
// Self-checking bench for c2h_dsc_byp_sched: directed scenarios plus random
// traffic compared every cycle against a transaction-level ring model.
module tb_c2h_dsc_byp_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [63:0] cfg_base_addr;
  logic        pkt_valid;
  logic [27:0] pkt_len;
  logic        pkt_ready;
  logic        credit_ret_valid;
  logic [4:0]  credit_ret_cnt;
  logic [63:0] dsc_byp_dst_addr;
  logic [63:0] dsc_byp_src_addr;
  logic [27:0] dsc_byp_len;
  logic [15:0] dsc_byp_ctl;
  logic        dsc_byp_load;
  logic        dsc_byp_ready;
  logic [4:0]  credits;
  logic [3:0]  slot_idx;
  logic [31:0] desc_count;
  logic        err_len;
  logic        err_credit_ovf;

  c2h_dsc_byp_sched dut (
    .user_clk         (clk),
    .user_resetn      (rst_n),
    .enable           (enable),
    .cfg_base_addr    (cfg_base_addr),
    .pkt_valid        (pkt_valid),
    .pkt_len          (pkt_len),
    .pkt_ready        (pkt_ready),
    .credit_ret_valid (credit_ret_valid),
    .credit_ret_cnt   (credit_ret_cnt),
    .dsc_byp_dst_addr (dsc_byp_dst_addr),
    .dsc_byp_src_addr (dsc_byp_src_addr),
    .dsc_byp_len      (dsc_byp_len),
    .dsc_byp_ctl      (dsc_byp_ctl),
    .dsc_byp_load     (dsc_byp_load),
    .dsc_byp_ready    (dsc_byp_ready),
    .credits          (credits),
    .slot_idx         (slot_idx),
    .desc_count       (desc_count),
    .err_len          (err_len),
    .err_credit_ovf   (err_credit_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Ring model: one outstanding descriptor at most, integer slot/credit counts.
  logic        m_en_prev, m_busy, m_ovf;
  int          m_slot, m_credits;
  logic [31:0] m_count;
  logic [63:0] m_base, m_dst;
  logic [27:0] m_len;
  logic        consumed;

  // DUT values observed at the last sampling point.
  logic        d_load, d_ready, d_err, d_ovf;
  logic [63:0] d_dst;
  logic [27:0] d_len;
  logic [4:0]  d_credits;
  logic [3:0]  d_slot;
  logic [31:0] d_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en_prev = 1'b0; m_busy = 1'b0; m_ovf = 1'b0;
    m_slot = 0; m_credits = 16; m_count = '0;
    m_base = '0; m_dst = '0; m_len = '0;
    consumed = 1'b0;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model.
  task automatic cycle();
    logic legal, consid, acc, iss, rise, x_err, x_rdy;
    int   ret, c;
    @(negedge clk);
    legal  = (pkt_len != 28'd0) && (pkt_len <= 28'd4096);
    consid = !m_busy && enable && m_en_prev && pkt_valid;
    x_err  = consid && !legal;
    acc    = m_busy && dsc_byp_ready;
    x_rdy  = x_err || acc;
    chk("load",       64'(dsc_byp_load),   64'(m_busy));
    chk("pkt_ready",  64'(pkt_ready),      64'(x_rdy));
    chk("err_len",    64'(err_len),        64'(x_err));
    chk("credits",    64'(credits),        64'(m_credits));
    chk("slot_idx",   64'(slot_idx),       64'(m_slot));
    chk("desc_count", 64'(desc_count),     64'(m_count));
    chk("ovf",        64'(err_credit_ovf), 64'(m_ovf));
    if (m_busy) begin
      chk("dst", dsc_byp_dst_addr, m_dst);
      chk("len", 64'(dsc_byp_len), 64'(m_len));
    end
    d_load = dsc_byp_load; d_ready = pkt_ready; d_err = err_len; d_ovf = err_credit_ovf;
    d_dst = dsc_byp_dst_addr; d_len = dsc_byp_len; d_credits = credits;
    d_slot = slot_idx; d_count = desc_count;
    consumed = x_rdy;
    iss  = consid && legal && (m_credits > 0);
    rise = enable && !m_en_prev;
    ret  = credit_ret_valid ? int'(credit_ret_cnt) : 0;
    if (acc) begin
      m_count = m_count + 32'd1;
      m_busy  = 1'b0;
    end
    if (iss) begin
      m_busy = 1'b1;
      m_dst  = m_base + 64'(m_slot) * 64'd4096;
      m_len  = pkt_len;
    end
    if (rise) begin
      m_base = cfg_base_addr; m_slot = 0; m_credits = 16; m_ovf = 1'b0;
    end else begin
      if (acc) m_slot = (m_slot + 1) % 16;
      c = m_credits - (acc ? 1 : 0) + ret;
      if (c > 16) begin
        c = 16;
        m_ovf = 1'b1;
      end
      m_credits = c;
    end
    m_en_prev = enable;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [27:0] len, input int maxc, output int ncyc,
                      output int first_load, output logic [63:0] dst_seen, output logic err_seen);
    pkt_valid = 1'b1; pkt_len = len;
    ncyc = 0; first_load = -1; dst_seen = '0; err_seen = 1'b0;
    do begin
      cycle();
      if (d_load && first_load < 0) begin
        first_load = ncyc;
        dst_seen   = d_dst;
      end
      if (d_err) err_seen = 1'b1;
      ncyc++;
    end while (!consumed && ncyc < maxc);
    checks++;
    if (!consumed) begin
      errors++;
      $display("FAIL send_timeout actual=%0d cycles required=consumed within %0d", ncyc, maxc);
    end
    pkt_valid = 1'b0;
  endtask

  function automatic logic [27:0] rand_len();
    case ($urandom_range(0, 9))
      0:       return 28'd0;
      1:       return 28'd4097;
      2:       return 28'd4096;
      3:       return 28'd1;
      4:       return 28'hFFF_FFFF;
      default: return 28'($urandom_range(1, 4096));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, fl;
    logic [63:0] dst;
    logic        e;
    logic [63:0] t1_exp [3];
    t1_exp = '{64'h1_0000_0000, 64'h1_0000_1000, 64'h1_0000_2000};

    rst_n = 1'b0; enable = 1'b0; cfg_base_addr = '0; pkt_valid = 1'b0; pkt_len = '0;
    credit_ret_valid = 1'b0; credit_ret_cnt = '0; dsc_byp_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_load",    64'(dsc_byp_load),   64'd0);
    chk("rst_ready",   64'(pkt_ready),      64'd0);
    chk("rst_credits", 64'(credits),        64'd16);
    chk("rst_slot",    64'(slot_idx),       64'd0);
    chk("rst_count",   64'(desc_count),     64'd0);
    chk("rst_ctl",     64'(dsc_byp_ctl),    64'h0000);
    chk("rst_src",     dsc_byp_src_addr,    64'd0);
    chk("rst_dst",     dsc_byp_dst_addr,    64'd0);
    chk("rst_ovf",     64'(err_credit_ovf), 64'd0);
    chk("rst_err",     64'(err_len),        64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: three back-to-back packets, ready tied high
    cfg_base_addr = 64'h1_0000_0000; enable = 1'b1;
    cycle(); cycle();
    for (int i = 0; i < 3; i++) begin
      send(28'h1000, 10, n, fl, dst, e);
      chk("t1_dst", dst, t1_exp[i]);
      chk("t1_latency", 64'(fl), 64'd1);
      chk("t1_cycles", 64'(n), 64'd2);
    end
    cycle();
    chk("t1_count", 64'(d_count), 64'd3);
    chk("t1_credits", 64'(d_credits), 64'd13);

    // 2: drain the ring, stall, then recover with a return of 2
    enable = 1'b0; cycle();
    enable = 1'b1; cycle(); cycle();
    chk("t2_reinit_credits", 64'(d_credits), 64'd16);
    for (int i = 0; i < 16; i++) send(28'h1000, 10, n, fl, dst, e);
    pkt_valid = 1'b1; pkt_len = 28'h1000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t2_stall_ready", 64'(d_ready), 64'd0);
      chk("t2_stall_load", 64'(d_load), 64'd0);
    end
    chk("t2_zero_credits", 64'(d_credits), 64'd0);
    credit_ret_valid = 1'b1; credit_ret_cnt = 5'd2;
    cycle();
    credit_ret_valid = 1'b0; credit_ret_cnt = '0;
    send(28'h1000, 10, n, fl, dst, e);
    chk("t2_wrap_dst", dst, 64'h1_0000_0000);
    cycle();
    chk("t2_credits", 64'(d_credits), 64'd1);
    chk("t2_slot", 64'(d_slot), 64'd1);

    // 3: illegal lengths are dropped with an error pulse
    send(28'd0, 5, n, fl, dst, e);
    chk("t3_zero_err", 64'(e), 64'd1);
    chk("t3_zero_noload", 64'(fl), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_zero_cycles", 64'(n), 64'd1);
    send(28'h1001, 5, n, fl, dst, e);
    chk("t3_big_err", 64'(e), 64'd1);
    chk("t3_big_noload", 64'(fl), 64'hFFFF_FFFF_FFFF_FFFF);
    cycle();
    chk("t3_credits", 64'(d_credits), 64'd1);
    chk("t3_slot", 64'(d_slot), 64'd1);
    chk("t3_count", 64'(d_count), 64'd20);

    // 4: backpressure in LOAD with enable dropping mid-way
    credit_ret_valid = 1'b1; credit_ret_cnt = 5'd4;
    cycle();
    credit_ret_valid = 1'b0; credit_ret_cnt = '0;
    dsc_byp_ready = 1'b0; pkt_valid = 1'b1; pkt_len = 28'h800;
    cycle();
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) enable = 1'b0;
      cycle();
      chk("t4_hold_load", 64'(d_load), 64'd1);
      chk("t4_hold_dst", d_dst, 64'h1_0000_1000);
      chk("t4_hold_len", 64'(d_len), 64'h800);
    end
    dsc_byp_ready = 1'b1;
    cycle();
    chk("t4_accept", 64'(d_ready), 64'd1);
    pkt_valid = 1'b1; pkt_len = 28'h100;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t4_no_issue", 64'(d_load), 64'd0);
    end
    pkt_valid = 1'b0; enable = 1'b1;
    cycle(); cycle(); cycle();
    chk("t4_reinit_credits", 64'(d_credits), 64'd16);
    chk("t4_count", 64'(d_count), 64'd21);

    // 5: credit overflow and simultaneous accept/return
    credit_ret_valid = 1'b1; credit_ret_cnt = 5'd1;
    cycle();
    credit_ret_valid = 1'b0; credit_ret_cnt = '0;
    cycle();
    chk("t5_sat_credits", 64'(d_credits), 64'd16);
    chk("t5_ovf", 64'(d_ovf), 64'd1);
    dsc_byp_ready = 1'b0; pkt_valid = 1'b1; pkt_len = 28'h40;
    cycle(); cycle();
    dsc_byp_ready = 1'b1; credit_ret_valid = 1'b1; credit_ret_cnt = 5'd1;
    cycle();
    chk("t5_accept", 64'(d_ready), 64'd1);
    credit_ret_valid = 1'b0; credit_ret_cnt = '0; pkt_valid = 1'b0;
    cycle();
    chk("t5_credits", 64'(d_credits), 64'd16);
    chk("t5_count", 64'(d_count), 64'd22);
    chk("t5_ovf_sticky", 64'(d_ovf), 64'd1);

    // Random traffic with enable held high
    enable = 1'b0; cycle();
    enable = 1'b1; cfg_base_addr = 64'hABCD_0000_0000_0000; cycle(); cycle();
    consumed = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if (!pkt_valid || consumed) begin
        if ($urandom_range(0, 2) != 0) begin
          pkt_valid = 1'b1;
          pkt_len   = rand_len();
        end else begin
          pkt_valid = 1'b0;
        end
      end
      dsc_byp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        credit_ret_valid = 1'b1;
        if ($urandom_range(0, 199) == 0) credit_ret_cnt = 5'($urandom_range(1, 31));
        else                             credit_ret_cnt = 5'($urandom_range(0, 16 - m_credits));
      end else begin
        credit_ret_valid = 1'b0;
        credit_ret_cnt   = '0;
      end
      cycle();
    end

    // 6: asynchronous reset while a descriptor is loaded
    pkt_valid = 1'b0; dsc_byp_ready = 1'b1; credit_ret_valid = 1'b0; credit_ret_cnt = '0;
    cycle(); cycle();
    credit_ret_valid = 1'b1; credit_ret_cnt = 5'(16 - m_credits);
    cycle();
    credit_ret_valid = 1'b0; credit_ret_cnt = '0;
    dsc_byp_ready = 1'b0; pkt_valid = 1'b1; pkt_len = 28'h200;
    cycle(); cycle();
    chk("t6_load_before", 64'(d_load), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_load_dropped", 64'(dsc_byp_load), 64'd0);
    chk("t6_credits", 64'(credits), 64'd16);
    chk("t6_count", 64'(desc_count), 64'd0);
    chk("t6_slot", 64'(slot_idx), 64'd0);
    pkt_valid = 1'b0; enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
